// File: rtl/ram_delay_line.sv
// ============================================================================
// ram_delay_line : circular sample buffer streaming the newest TAPS samples
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ram_delay_line #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] tap_idx,
  output logic                  last,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (TAPS < 1 || TAPS > DEPTH) begin : g_taps_range_check
    $error("ram_delay_line: TAPS must be within 1..DEPTH");
  end

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, clr_cnt, base, k;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic                  re;
  logic [ADDR_WIDTH-1:0] ra;

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    wa       = wr_ptr;
    wd       = sample_in;
    re       = 1'b0;
    ra       = base - k;
    case (state)
      CLEAR: begin
        we = 1'b1;
        wa = clr_cnt;
        wd = '0;
        if (clr_cnt == LAST_ADDR) state_nx = IDLE;
      end
      IDLE: begin
        // A held-over sample always lands before the one arriving now
        if (pend_valid) begin
          we = 1'b1;
          wd = pend_data;
        end else if (sample_valid) begin
          we = 1'b1;
        end
        if (start) state_nx = READ;
      end
      READ: begin
        re = 1'b1;
        if (k == LAST_TAP) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      clr_cnt    <= '0;
      base       <= '0;
      k          <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overflow   <= 1'b0;
      ready      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      tap_idx    <= '0;
      last       <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) ready <= 1'b1;
        end
        IDLE: begin
          if (we) wr_ptr <= wr_ptr + 1'b1;
          if (pend_valid) begin
            pend_valid <= sample_valid;
            pend_data  <= sample_in;
          end
          // Newest sample is the one written this cycle, if any
          if (start) begin
            base <= we ? wr_ptr : wr_ptr - 1'b1;
            k    <= '0;
          end
        end
        READ: begin
          k <= k + 1'b1;
          if (sample_valid) begin
            if (pend_valid) overflow <= 1'b1;
            pend_valid <= 1'b1;
            pend_data  <= sample_in;
          end
        end
        default: ;
      endcase

      data_valid <= re;
      last       <= re && (k == LAST_TAP);
      if (re) begin
        data_out <= mem[ra];
        tap_idx  <= k;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/ram_delay_line.md
# ram_delay_line

Parametrised circular sample buffer for the FIR datapath: the next generation of the plain single-port RAM. It stores incoming samples in a dual-port memory with a wrapping write pointer. On request it streams the most recent TAPS samples, newest first, with tap index and framing for the MAC stage. After reset it self-clears the memory, and it buffers one sample arriving during a readout.

## Interface
- ADDR_WIDTH, 5, address width; DEPTH = 2^ADDR_WIDTH entries
- DATA_WIDTH, 16, sample width
- TAPS, 2^ADDR_WIDTH, samples streamed per readout; legal 1..DEPTH (simulation-time check)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  DATA_WIDTH  new sample
- sample_valid  in  1  sample_in valid this cycle
- start  in  1  request readout (single-cycle pulse or level)
- ready  out  1  memory clear complete
- busy  out  1  state is not IDLE
- data_out  out  DATA_WIDTH  registered tap sample
- data_valid  out  1  data_out valid this cycle
- tap_idx  out  ADDR_WIDTH  tap number of data_out, 0 = newest
- last  out  1  data_valid on tap TAPS-1
- overflow  out  1  sticky; pending sample was overwritten

## Operation
- Memory is one write port and one synchronous read port, with the same clock.
- States: CLEAR, IDLE, READ.
- Reset: state=CLEAR, wr_ptr=0, clr_cnt=0, pending empty. Outputs: ready=0, busy=1, data_out=0, data_valid=0, tap_idx=0, last=0, overflow=0.
- CLEAR: writes 0 to address clr_cnt each cycle, for 0..DEPTH-1, then goes to IDLE and ready=1. ready stays 1 until the next reset. sample_valid and start are ignored and samples are dropped.
- IDLE, sample_valid=1: writes sample_in at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH (natural wrap).
- IDLE, start=1: latches base = address of the newest stored sample.
  - If a write happens in the same cycle (sample_valid or pending flush), base is that write address.
  - Otherwise base = wr_ptr-1 mod DEPTH.
  - Sets k=0 and enters READ.
- READ: each cycle issues read address (base - k) mod DEPTH, then k++. After k = TAPS-1 is issued, returns to IDLE.
- start during READ or CLEAR is ignored and not queued.
- sample_valid during READ: the sample goes to a one-entry pending register and is not written to memory.
  - If pending is already full, it is overwritten by the newer sample and overflow is set to 1.
  - overflow is cleared only by reset.
- Pending flush: in the first IDLE cycle the pending sample is written at wr_ptr and wr_ptr advances.
  - If sample_valid is also 1 that cycle, the pending sample is written first. sample_in is then held as the new pending and written the following cycle.
  - With no further sample_valid, the pending register is empty after the flush.
- Readout reflects memory as of the start cycle. Writes never occur while in READ.

## Timing
- start sampled in IDLE at edge t:
  - READ occupies cycles t+1..t+TAPS; busy=1 in t+1..t+TAPS.
  - Read address for tap k is issued at t+1+k.
  - data_valid=1 with tap k at cycle t+2+k; tap_idx=k.
  - last=1 at t+TAPS+1.
  - Latency from start to first data_valid: 2 cycles.
- IDLE at t+TAPS+1: a new start is accepted in that same cycle, so back-to-back readouts have a 1-cycle gap in data_valid.
- data_out holds its last value when data_valid=0. data_valid, last and tap_idx are registered alongside data_out.
- CLEAR lasts exactly DEPTH cycles after rst_n deasserts, with ready=1 on the following cycle.
- Asserting rst_n mid-operation aborts READ or CLEAR immediately. All outputs take reset values, CLEAR restarts, and stored data and pending are lost.

## Test plan
- ADDR_WIDTH=3, TAPS=8. Release reset: busy=1 and ready=0 for 8 cycles, then ready=1. Immediate start gives eight zeros, tap_idx 0..7, last on tap 7.
- Write 1..5, then start: data_out 5,4,3,2,1,0,0,0. First data_valid is 2 cycles after start.
- Wrap: write 1..11, then start: data_out 11,10,...,4. With TAPS=3: 11,10,9.
- start with sample_valid=1 and sample_in=20 in the same cycle (after previous contents 1..5): first tap is 20, then 5,4,3,...
- Samples 30 then 31 during READ: overflow=1, 30 is lost. 31 is written in the first IDLE cycle; the next readout starts 31, then previous newest.
- Assert rst_n low at tap 3 of a READ: data_valid drops immediately, ready=0 and overflow=0, CLEAR reruns. The next readout returns all zeros.
